// File: rtl/fir_src_pkg.sv
// Shared definitions for the FIR stimulus source: playback states and the
// default widths that match the FIR_Filter datapath.
package fir_src_pkg;

  // Playback controller states
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } src_state_e;

  // Default sample width and buffer address width shared with FIR_Filter
  localparam int unsigned N_DEF     = 16;
  localparam int unsigned ADDR_DEF  = 5;
  // Default width of the sample-period divider
  localparam int unsigned DIV_W_DEF = 8;

endpackage : fir_src_pkg

// File: rtl/sample_ram.sv
// Sample buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded pattern survives a reset.
module sample_ram #(
  parameter int unsigned N    = 16,
  parameter int unsigned ADDR = 5
) (
  input  logic            clk_i,
  input  logic            wr_en_i,
  input  logic [ADDR-1:0] wr_addr_i,
  input  logic [N-1:0]    wr_data_i,
  input  logic [ADDR-1:0] rd_addr_i,
  output logic [N-1:0]    rd_data_o
);

  logic [N-1:0] mem_q [2**ADDR];

  // Synchronous write; a read of the same word in the same cycle sees old data
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : sample_ram

// File: rtl/fir_sample_source.sv
// Programmable sample source feeding the FIR_Filter Xin stream.
// Plays a buffer once or in a loop with a programmable period, then drives
// zeros so the filter flushes. All outputs are registered.
module fir_sample_source
  import fir_src_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned ADDR  = ADDR_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             wr_en,
  input  logic [ADDR-1:0]  wr_addr,
  input  logic [N-1:0]     wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [ADDR-1:0]  len,
  input  logic [DIV_W-1:0] div,
  output logic [N-1:0]     Xout,
  output logic             Xvalid,
  output logic             busy,
  output logic             done
);

  localparam logic [ADDR-1:0]  ADDR_ONE = ADDR'(1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  src_state_e       state_q,  state_d;
  logic [ADDR-1:0]  addr_q,   addr_d;
  logic [DIV_W-1:0] cnt_q,    cnt_d;
  logic [ADDR-1:0]  len_q,    len_d;
  logic [DIV_W-1:0] div_q,    div_d;
  logic             final_q,  final_d;   // last sample of a one-shot pass issued
  logic [N-1:0]     xout_q,   xout_d;
  logic             xvalid_q, xvalid_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [N-1:0]     rd_data_s;

  sample_ram #(
    .N    (N),
    .ADDR (ADDR)
  ) u_ram (
    .clk_i     (Clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (addr_q),
    .rd_data_o (rd_data_s)
  );

  // Next-state logic: start/stop handling, period counter, sample issue
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    div_d    = div_q;
    final_d  = final_q;
    xout_d   = xout_q;
    xvalid_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        xout_d = '0;
        busy_d = 1'b0;
        if (start && !stop) begin
          state_d = S_PLAY;
          len_d   = len;
          div_d   = div;
          addr_d  = '0;
          cnt_d   = '0;
          final_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PLAY: begin
        busy_d = 1'b1;
        if (stop) begin
          // Abort: zero the outputs, no done pulse
          state_d = S_IDLE;
          addr_d  = '0;
          cnt_d   = '0;
          final_d = 1'b0;
          xout_d  = '0;
          busy_d  = 1'b0;
        end else begin
          // cnt walks 0..div_q; the compare-to-wrap needs no extra width
          if (cnt_q == div_q) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end

          if (cnt_q == '0) begin
            if (final_q) begin
              // One period after the final sample: finish the pass
              state_d = S_IDLE;
              addr_d  = '0;
              cnt_d   = '0;
              final_d = 1'b0;
              xout_d  = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              xout_d   = rd_data_s;
              xvalid_d = 1'b1;
              if (addr_q != len_q) begin
                addr_d = addr_q + ADDR_ONE;
              end else if (loop) begin
                addr_d = '0;
              end else begin
                final_d = 1'b1;
              end
            end
          end else begin
            xvalid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        cnt_d   = '0;
        final_d = 1'b0;
        xout_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, latched controls and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      div_q    <= '0;
      final_q  <= 1'b0;
      xout_q   <= '0;
      xvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      div_q    <= div_d;
      final_q  <= final_d;
      xout_q   <= xout_d;
      xvalid_q <= xvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Xout   = xout_q;
  assign Xvalid = xvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule : fir_sample_source

// File: doc/fir_sample_source.md
# fir_sample_source

Upstream stimulus stage for `FIR_Filter`. Holds a 32-entry buffer of N-bit samples loaded through a write port, and plays it out as the filter's `Xin` stream. Playback is one-shot or looped, with a programmable sample period. After playback it drives zeros so the filter flushes cleanly. It replaces the free-running address counter plus `$readmemb` RAM with a synthesizable, controllable source.

## Interface
- `N`, 16, sample width (matches `FIR_Filter`)
- `ADDR`, 5, buffer address width; depth = 2^ADDR
- `DIV_W`, 8, width of the period divider

Ports:
- `Clk`  in  1  system clock, rising edge
- `Rst`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  buffer write strobe
- `wr_addr`  in  ADDR  buffer write address
- `wr_data`  in  N  buffer write data
- `start`  in  1  begin playback (honoured only in IDLE)
- `stop`  in  1  abort playback
- `loop`  in  1  wrap to index 0 after index `len` instead of finishing
- `len`  in  ADDR  index of the last sample played; latched at start
- `div`  in  DIV_W  sample period minus one; latched at start
- `Xout`  out  N  sample to the filter `Xin`; registered
- `Xvalid`  out  1  one-cycle strobe, new sample on `Xout`
- `busy`  out  1  high while in PLAY
- `done`  out  1  one-cycle pulse at normal end of a one-shot pass

## Operation
- The buffer is 2^ADDR x N.
  - Writes are synchronous and accepted in any state.
  - Reads are asynchronous.
  - Contents are not cleared by `Rst`.
- The FSM has two states, IDLE and PLAY. All outputs are registered.
- **IDLE:**
  - `Xout`=0, `Xvalid`=0, `busy`=0.
  - When `start`=1 and `stop`=0: latch `len` and `div`, set `addr`=0 and `cnt`=0, then go to PLAY.
  - When `start` and `stop` are both high, stay in IDLE.
- **PLAY:**
  - `cnt` counts 0..`div_q`, then wraps to 0.
  - When `cnt`==0, one sample is issued:
    - `Xout`<=buf[`addr`] and `Xvalid`<=1 on the next edge.
    - Then, if `addr`!=`len_q`: `addr`+1.
    - If `addr`==`len_q` and `loop`=1: `addr`=0.
    - If `addr`==`len_q` and `loop`=0: mark the final issue.
  - Between issues, `Xout` holds its value and `Xvalid`=0.
  - `loop` is sampled live at each wrap point. Clearing it mid-pass ends playback after the current pass.
- **End of a one-shot pass:** at the `cnt`==0 point following the final issue, go to IDLE.
  - In that cycle: `done`=1, `Xout`=0, `Xvalid`=0, `busy`=0.
- **`stop` in PLAY:** go to IDLE on the next edge. The outputs are zeroed, no further `Xvalid` is issued, and `done` stays 0.
- **`start` in PLAY:** ignored.
- **`Rst` (any state, mid-play included):** on the next edge, state=IDLE, `addr`=0, `cnt`=0 and all outputs 0.
- **Write to the address being read in the same cycle:** the read returns the old data. The new value appears on the next visit to that address.
- **`len`=0:** a single sample is played. With `loop`=1 it repeats every `div`+1 cycles.

## Timing
- `start` sampled high at edge t:
  - `busy`=1 from cycle t+1.
  - First `Xvalid` and `Xout`=buf[0] in cycle t+2.
- Strobes follow every `div`+1 cycles. `div`=0 gives back-to-back samples, one per clock.
- One-shot pass with k=`len`+1 samples:
  - Last `Xvalid` at t+2+(k-1)(`div`+1).
  - `done` and `Xout`=0 occur `div`+1 cycles after the last `Xvalid`.
- `stop` at edge s: outputs are 0 from cycle s+1.
- Period accuracy: `cnt` needs no extra width; `div`=2^DIV_W-1 is legal.

## Structure
- Package `fir_src_pkg`: state enum (`S_IDLE`, `S_PLAY`) and default width constants shared with `FIR_Filter` (N=16, ADDR=5).
- Sub-module `sample_ram`: N-bit x 2^ADDR, one synchronous write port, one asynchronous read port.
- Top level: FSM, `addr`/`cnt` counters, latched `len_q`/`div_q`, output registers.

## Test plan
- **Impulse.** Load buf[0]=16'h0001 and the rest 0; `len`=31, `div`=0, `loop`=0.
  - Expect 32 consecutive `Xvalid` from t+2, with `Xout`=1 only in the first.
  - Expect `done` at t+34 with `Xout`=0 and `busy`=0.
- **Divider.** Load buf[0..3]=1,2,3,4; `len`=3, `div`=3.
  - Expect strobes at t+2, t+6, t+10, t+14 carrying 1,2,3,4, with `Xout` held between strobes.
  - Expect `done` at t+18.
- **Loop / stop.** Same data, `loop`=1, `div`=0.
  - Expect `Xout` 1,2,3,4,1,2,... on consecutive cycles.
  - Assert `stop` after the second "2": `Xout`=0 and `Xvalid`=0 on the next cycle, `done` never asserted.
- **Reset mid-play.** Pulse `Rst` during PLAY.
  - Expect all outputs 0 on the next cycle.
  - A following `start` replays from buf[0] with the data unchanged.
- **Control corner cases.**
  - `start` during PLAY is ignored: no restart, strobe cadence unchanged.
  - `start` and `stop` together in IDLE: `busy` stays 0.
  - Clearing `loop` mid-pass ends playback after index `len`.
- **Write during play.** Write buf[1]=16'h00AA while looping, after index 1 has played.
  - The current pass is unchanged; the next pass emits 16'h00AA at index 1.
